// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central hazard controller for the 5-stage MIPS-lite pipeline. It covers
//   these functions:
//     - N-source EX operand forwarding.
//     - Load-use stall detection.
//     - Multi-cycle EX (MUL/DIV) stall sequencing.
//     - Branch/jump flushes.
//   Optional build macro: HAZARD_PERF_EN adds three 32-bit performance
//   counters (stall cycles, flush cycles, unmasked load-use cycles).
//   Control outputs are combinational decodes of the stage fields and the
//   registered multi-cycle state. They are forced low while rst is high, so
//   the pipeline sees quiet controls during reset.
module pipeline_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int MUL_LAT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src_addr,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic [NUM_SRC*REG_AW-1:0]   ex_src_addr,
  input  logic [REG_AW-1:0]           ex_dst_addr,
  input  logic                        ex_reg_write,
  input  logic                        ex_mem_read,
  input  logic                        ex_multi,
  input  logic                        branch_taken,
  input  logic [REG_AW-1:0]           mem_dst_addr,
  input  logic                        mem_reg_write,
  input  logic [REG_AW-1:0]           wb_dst_addr,
  input  logic                        wb_reg_write,
  output logic [NUM_SRC*2-1:0]        fwd_sel,
  output logic                        stall_f,
  output logic                        stall_d,
  output logic                        stall_e,
  output logic                        flush_d,
  output logic                        flush_e,
  output logic                        bubble_m,
  output logic                        busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                 perf_stall_cnt,
  output logic [31:0]                 perf_flush_cnt,
  output logic [31:0]                 perf_lu_cnt
`endif
);

  localparam int CW = $clog2(MUL_LAT) + 1;
  // Value of the residency counter on the final EX cycle of a multi-cycle op.
  localparam logic [CW-1:0] CYC_LAST = CW'(MUL_LAT - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cyc_q, cyc_d;

  logic           lu_raw_s;
  logic           stall_e_s;
  logic           br_s;
  logic           lu_s;

  // Per-source forwarding select. MEM wins over WB, and register 0 never forwards.
  always_comb begin
    fwd_sel = '0;
    if (!rst) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (mem_reg_write && (mem_dst_addr != '0) &&
            (mem_dst_addr == ex_src_addr[k*REG_AW +: REG_AW])) begin
          fwd_sel[k*2 +: 2] = 2'b10;
        end else if (wb_reg_write && (wb_dst_addr != '0) &&
                     (wb_dst_addr == ex_src_addr[k*REG_AW +: REG_AW])) begin
          fwd_sel[k*2 +: 2] = 2'b01;
        end else begin
          fwd_sel[k*2 +: 2] = 2'b00;
        end
      end
    end else begin
      fwd_sel = '0;
    end
  end

  // Raw load-use detection: a load in EX targets a register that ID actually reads.
  always_comb begin
    lu_raw_s = 1'b0;
    if (!rst && ex_mem_read && ex_reg_write && (ex_dst_addr != '0)) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (id_src_used[k] && (id_src_addr[k*REG_AW +: REG_AW] == ex_dst_addr)) begin
          lu_raw_s = 1'b1;
        end else begin
          lu_raw_s = lu_raw_s;
        end
      end
    end else begin
      lu_raw_s = 1'b0;
    end
  end

  // Event arbitration. The priority order is branch flush, then the
  // multi-cycle stall, then load-use. A branch is ignored while EX holds.
  always_comb begin
    stall_e_s = 1'b0;
    br_s      = 1'b0;
    lu_s      = 1'b0;
    if (!rst) begin
      stall_e_s = ex_multi && (cyc_q < CYC_LAST);
      br_s      = branch_taken && !stall_e_s;
      lu_s      = lu_raw_s && !stall_e_s && !br_s;
    end else begin
      stall_e_s = 1'b0;
      br_s      = 1'b0;
      lu_s      = 1'b0;
    end
  end

  // Pipeline register controls derived from the arbitrated events.
  always_comb begin
    stall_e  = stall_e_s;
    bubble_m = stall_e_s;
    stall_f  = stall_e_s | lu_s;
    stall_d  = stall_e_s | lu_s;
    flush_d  = br_s;
    flush_e  = br_s | lu_s;
  end

  // Multi-cycle residency: count stalled cycles, and clear on the op's final cycle or once EX is idle.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    if (stall_e_s) begin
      cyc_d   = cyc_q + CW'(1);
      state_d = ST_BUSY;
    end else begin
      cyc_d   = '0;
      state_d = ST_IDLE;
    end
  end

  // Multi-cycle FSM state and residency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
    end
  end

  assign busy = (state_q == ST_BUSY);

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_lu_q,    perf_lu_d;

  // Performance counter increments. All three counters wrap naturally at 2^32.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    perf_lu_d    = perf_lu_q;
    if (stall_f) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end else begin
      perf_stall_d = perf_stall_q;
    end
    if (flush_d) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end else begin
      perf_flush_d = perf_flush_q;
    end
    if (lu_s) begin
      perf_lu_d = perf_lu_q + 32'd1;
    end else begin
      perf_lu_d = perf_lu_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
      perf_lu_q    <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_lu_q    <= perf_lu_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
  assign perf_lu_cnt    = perf_lu_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl (default parameters, HAZARD_PERF_EN undefined).
// The driver issues one stimulus vector per cycle and queues the expected
// outputs, which come from a reference model. A monitor on the falling edge
// pops each entry and compares it with the DUT.
module tb_pipeline_hazard_ctrl;

  localparam int AW  = 5;
  localparam int NS  = 2;
  localparam int LAT = 4;

  typedef struct packed {
    logic          rst;
    logic [NS*AW-1:0] id_src;
    logic [NS-1:0] id_used;
    logic [NS*AW-1:0] ex_src;
    logic [AW-1:0] ex_dst;
    logic          ex_rw;
    logic          ex_mr;
    logic          ex_multi;
    logic          br;
    logic [AW-1:0] mem_dst;
    logic          mem_rw;
    logic [AW-1:0] wb_dst;
    logic          wb_rw;
  } stim_t;

  // ctrl packing: {stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m, busy}
  typedef struct packed {
    logic [NS*2-1:0] fwd;
    logic [6:0]      ctrl;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  stim_t cur;
  stim_t nx;

  logic [NS*2-1:0] fwd_sel;
  logic stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m, busy;

  pipeline_hazard_ctrl #(.REG_AW(AW), .NUM_SRC(NS), .MUL_LAT(LAT)) dut (
    .clk          (clk),
    .rst          (cur.rst),
    .id_src_addr  (cur.id_src),
    .id_src_used  (cur.id_used),
    .ex_src_addr  (cur.ex_src),
    .ex_dst_addr  (cur.ex_dst),
    .ex_reg_write (cur.ex_rw),
    .ex_mem_read  (cur.ex_mr),
    .ex_multi     (cur.ex_multi),
    .branch_taken (cur.br),
    .mem_dst_addr (cur.mem_dst),
    .mem_reg_write(cur.mem_rw),
    .wb_dst_addr  (cur.wb_dst),
    .wb_reg_write (cur.wb_rw),
    .fwd_sel      (fwd_sel),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .stall_e      (stall_e),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .bubble_m     (bubble_m),
    .busy         (busy)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  // The model tracks how many cycles the current multi-cycle op has already spent in EX.
  int   op_age = 0;

  // Reference model. It computes the outputs directly from the hazard rules
  // and the op's EX residency.
  function automatic exp_t model(input stim_t s, input int age);
    exp_t e;
    bit   lu, st, br, lu_eff;
    int   sa, da;
    e = '0;
    if (s.rst) return e;
    for (int k = 0; k < NS; k++) begin
      sa = int'(s.ex_src[k*AW +: AW]);
      if (s.mem_rw && s.mem_dst != 0 && int'(s.mem_dst) == sa)      e.fwd[k*2 +: 2] = 2'b10;
      else if (s.wb_rw && s.wb_dst != 0 && int'(s.wb_dst) == sa)    e.fwd[k*2 +: 2] = 2'b01;
      else                                                          e.fwd[k*2 +: 2] = 2'b00;
    end
    lu = 0;
    da = int'(s.ex_dst);
    if (s.ex_mr && s.ex_rw && da != 0)
      for (int k = 0; k < NS; k++)
        if (s.id_used[k] && int'(s.id_src[k*AW +: AW]) == da) lu = 1;
    // An op with LAT cycles of EX residency holds the pipeline for every cycle except its last.
    st     = s.ex_multi && (age < LAT - 1);
    br     = s.br && !st;
    lu_eff = lu && !st && !br;
    e.ctrl = {st | lu_eff, st | lu_eff, st, br, br | lu_eff, st, age > 0};
    return e;
  endfunction

  // Apply nx for one cycle, queue its expected response and advance the model.
  task automatic drive();
    exp_t e;
    @(posedge clk);
    #1;
    cur = nx;
    e = model(cur, op_age);
    exp_q.push_back(e);
    if (cur.rst)                                op_age = 0;
    else if (cur.ex_multi && op_age < LAT - 1)  op_age = op_age + 1;
    else                                        op_age = 0;
  endtask

  // Monitor: compare the DUT outputs with the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc_no++;
        checks++;
        if (fwd_sel !== e.fwd) begin
          errors++;
          $display("FAIL fwd_sel cycle %0d: got %b expected %b", cyc_no, fwd_sel, e.fwd);
        end
        checks++;
        if ({stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m, busy} !== e.ctrl) begin
          errors++;
          $display("FAIL ctrl cycle %0d (sf sd se fd fe bm busy): got %b expected %b",
                   cyc_no, {stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m, busy}, e.ctrl);
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    int op_left;
    cur = '0;
    cur.rst = 1'b1;
    nx  = '0;
    nx.rst = 1'b1;
    drive(); drive();
    nx.rst = 1'b0;

    // Forwarding priority and the register-0 exclusion.
    nx.mem_dst = 5'd3; nx.mem_rw = 1'b1; nx.wb_dst = 5'd3; nx.wb_rw = 1'b1;
    nx.ex_src = {5'd0, 5'd3};
    drive();
    nx.mem_rw = 1'b0; drive();
    nx.mem_rw = 1'b1; nx.mem_dst = 5'd0; nx.wb_dst = 5'd0; nx.ex_src = {5'd3, 5'd0}; drive();
    nx = '0;

    // Load-use, followed by the load moving on to MEM.
    nx.ex_mr = 1'b1; nx.ex_rw = 1'b1; nx.ex_dst = 5'd5;
    nx.id_src = {5'd5, 5'd1}; nx.id_used = 2'b11;
    drive();
    nx.ex_mr = 1'b0; nx.ex_rw = 1'b0; nx.ex_dst = 5'd0;
    nx.mem_dst = 5'd5; nx.mem_rw = 1'b1;
    drive();
    nx = '0;
    nx.ex_mr = 1'b1; nx.ex_rw = 1'b1; nx.ex_dst = 5'd5;
    nx.id_src = {5'd5, 5'd1}; nx.id_used = 2'b01;
    drive();
    nx = '0;

    // Multi-cycle op held for LAT cycles.
    nx.ex_multi = 1'b1;
    repeat (LAT) drive();
    nx.ex_multi = 1'b0; drive();

    // A branch that coincides with load-use.
    nx.ex_mr = 1'b1; nx.ex_rw = 1'b1; nx.ex_dst = 5'd7;
    nx.id_src = {5'd0, 5'd7}; nx.id_used = 2'b01; nx.br = 1'b1;
    drive();
    nx = '0;

    // A branch arriving during a multi-cycle stall.
    nx.ex_multi = 1'b1; drive();
    nx.br = 1'b1; drive();
    nx.br = 1'b0; drive(); drive();
    nx.ex_multi = 1'b0; drive();

    // Reset pulsed on cycle 2 of a multi-cycle op, then a fresh op.
    nx.ex_multi = 1'b1; drive();
    nx.rst = 1'b1; drive();
    nx.rst = 1'b0; repeat (LAT) drive();
    nx = '0; drive();

    // Randomized traffic. Multi-cycle ops are held for their full LAT cycles.
    op_left = 0;
    for (int i = 0; i < 400; i++) begin
      nx.rst     = ($urandom_range(0, 99) == 0);
      nx.id_src  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      nx.id_used = 2'($urandom_range(0, 3));
      nx.ex_src  = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      nx.ex_dst  = 5'($urandom_range(0, 3));
      nx.ex_rw   = 1'($urandom_range(0, 1));
      nx.ex_mr   = ($urandom_range(0, 2) == 0);
      nx.br      = ($urandom_range(0, 4) == 0);
      nx.mem_dst = 5'($urandom_range(0, 3));
      nx.mem_rw  = 1'($urandom_range(0, 1));
      nx.wb_dst  = 5'($urandom_range(0, 3));
      nx.wb_rw   = 1'($urandom_range(0, 1));
      if (op_left == 0 && $urandom_range(0, 5) == 0) op_left = LAT;
      nx.ex_multi = (op_left > 0);
      if (op_left > 0) op_left--;
      drive();
    end
    nx = '0;
    drive();

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
